register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- 32-entry x 32-bit MIPS general-purpose register file with two combinational read ports and one synchronous write port.
- Sits directly downstream of the 5-bit 2:1 destination-register mux, which selects rt or rd under RegDst.
- The mux output drives WriteRegister.
- Reads feed the ID stage; writes come from the WB stage.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH = 32.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-low reset; sampled on rising edge of Clk.
- RegWrite  input  1  write enable from WB control.
- WriteRegister  input  5  destination index, from the destination-register mux.
- WriteData  input  32  value to write.
- ReadRegister1  input  5  rs index.
- ReadRegister2  input  5  rt index.
- ReadData1  output  32  contents of ReadRegister1.
- ReadData2  output  32  contents of ReadRegister2.

Behaviour:
- Storage: array R[0..31] of 32-bit registers.
- Reset: when Rst==0 at a rising Clk edge, all R[i] are set to 0x00000000.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Reset mid-operation discards any pending write.
  - After reset, ReadData1 and ReadData2 read 0 for every index.
- Write: at a rising edge with Rst==1 and RegWrite==1 and WriteRegister!=0, R[WriteRegister] <= WriteData.
  - Single-cycle write latency; the value is visible from the next cycle.
  - With RegWrite==0, no state changes.
- Register 0: hardwired zero.
  - Writes to index 0 are ignored and R[0] never changes.
  - Reads of index 0 always return 0x00000000, regardless of any write attempt.
- Read: fully combinational, zero cycle latency.
  - ReadDataN = (ReadRegisterN==0) ? 0 : R[ReadRegisterN].
  - Outputs change within the same cycle as the address changes.
- Both read ports may address the same register simultaneously; both return the identical value.
- Same-cycle read/write of the same nonzero index:
  - Without the optional feature, the read returns the old (pre-edge) value.
  - The new value appears after the edge.
- No X propagation: every register holds a defined value after the first reset edge.
- Output values before the first reset edge are not required to be defined.
- Width rules: no arithmetic. Indices are 5-bit unsigned and cover all 32 entries, so there are no out-of-range cases.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- When defined: internal write-before-read forwarding is enabled.
  - Condition: RegWrite==1, Rst==1, WriteRegister!=0, and ReadRegisterN==WriteRegister.
  - Under that condition, ReadDataN returns WriteData combinationally in the same cycle.
  - This resolves the WB-to-ID hazard without a half-cycle write.
  - Index 0 is never bypassed and still reads 0.
  - Bypass is suppressed while Rst==0, so reads return the stored or reset value.
- When undefined: no forwarding. Reads always reflect stored state only, as described in Behaviour.

Test Plan:
- Reset clear: preload R[5]=0xDEADBEEF; hold Rst=0 for one edge; read address 5 on both ports -> 0x00000000.
- Basic write/read: RegWrite=1, WriteRegister=8, WriteData=0x12345678, one edge; then ReadRegister1=8, ReadRegister2=8 -> both 0x12345678; R[9] reads 0.
- Register 0 protection: RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF, edge; ReadRegister1=0 -> 0x00000000.
- Write disabled: RegWrite=0, WriteRegister=3, WriteData=0xAAAA5555, edge -> R[3] keeps its prior value (0 after reset).
- Same-cycle hazard: R[10]=0x11111111; in one cycle RegWrite=1, WriteRegister=10, WriteData=0x22222222, ReadRegister1=10.
  - Without REGFILE_WRITE_BYPASS_EN: ReadData1=0x11111111 pre-edge, 0x22222222 post-edge.
  - With it: ReadData1=0x22222222 pre-edge.
- Reset vs write collision: Rst=0 and RegWrite=1, WriteRegister=4, WriteData=0x0000BEEF on the same edge -> R[4]=0x00000000 afterwards.

Source files
------------

// File: rtl/register_file_2r1w_if.sv
// rtl/register_file_2r1w_if.sv - register file read/write bus
// Master drives write and read indices; slave returns the two read values.
interface register_file_2r1w_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - 32x32 MIPS register file, two combinational reads, one synchronous write
// Optional REGFILE_WRITE_BYPASS_EN forwards same-cycle WriteData to a matching read port.
module register_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  register_file_2r1w_if.slave   rf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  // Entry 0 is only ever loaded by reset; the write guard keeps it at zero.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (rf.RegWrite && (rf.WriteRegister != '0)) begin
      regs[rf.WriteRegister] <= rf.WriteData;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic wr_live;
  assign wr_live = Rst && rf.RegWrite && (rf.WriteRegister != '0);
`endif

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rf.ReadRegister1 != '0) rd1 = regs[rf.ReadRegister1];
    if (rf.ReadRegister2 != '0) rd2 = regs[rf.ReadRegister2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // wr_live already excludes index 0, so a zero read index can never match.
    if (wr_live && (rf.ReadRegister1 == rf.WriteRegister)) rd1 = rf.WriteData;
    if (wr_live && (rf.ReadRegister2 == rf.WriteRegister)) rd2 = rf.WriteData;
`endif
  end

  assign rf.ReadData1 = rd1;
  assign rf.ReadData2 = rd2;
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - scoreboard bench for register_file_2r1w
// Stimulus pushes expected read values; a monitor process pops and compares them.
module tb_register_file_2r1w;
  logic Clk = 1'b0;
  logic Rst = 1'b0;

  always #5 Clk = ~Clk;

  register_file_2r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .rf  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   vectors     = 0;
  int   miscompares = 0;

  `ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
  `else
  localparam bit BYPASS = 1'b0;
  `endif

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.ReadData1 !== e.e1 || bus.ReadData2 !== e.e2) begin
          miscompares++;
          $display("FAIL %s: rd1=%h rd2=%h expected rd1=%h rd2=%h",
                   e.name, bus.ReadData1, bus.ReadData2, e.e1, e.e2);
        end
      end
    end
  end

  task automatic check(input string name, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    bus.ReadRegister1 = a1;
    bus.ReadRegister2 = a2;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
    -> sample_ev;
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: monitor did not consume entry, queue depth %0d expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    @(negedge Clk);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = a;
    bus.WriteData     = d;
    @(posedge Clk);
    @(negedge Clk);
    bus.RegWrite      = 1'b0;
  endtask

  initial begin
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData     = '0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;

    check("reset_r0_r31", 5'd0, 5'd31, 32'h0, 32'h0);
    check("reset_r1_r16", 5'd1, 5'd16, 32'h0, 32'h0);

    // Preload then reset clears it
    write(5'd5, 32'hDEADBEEF);
    check("preload_r5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    Rst = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    check("reset_clears_r5", 5'd5, 5'd5, 32'h0, 32'h0);

    write(5'd8, 32'h12345678);
    check("write_r8_both", 5'd8, 5'd8, 32'h12345678, 32'h12345678);
    check("r9_untouched", 5'd9, 5'd8, 32'h0, 32'h12345678);

    write(5'd0, 32'hFFFFFFFF);
    check("r0_protect", 5'd0, 5'd8, 32'h0, 32'h12345678);

    @(negedge Clk);
    bus.RegWrite = 1'b0; bus.WriteRegister = 5'd3; bus.WriteData = 32'hAAAA5555;
    @(posedge Clk);
    @(negedge Clk);
    check("write_disabled_r3", 5'd3, 5'd3, 32'h0, 32'h0);

    write(5'd31, 32'hCAFEF00D);
    write(5'd1, 32'h00000001);
    check("ports_differ_31_1", 5'd31, 5'd1, 32'hCAFEF00D, 32'h00000001);

    // Same-cycle write/read of R10
    write(5'd10, 32'h11111111);
    @(negedge Clk);
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd10; bus.WriteData = 32'h22222222;
    check("hazard_pre_edge", 5'd10, 5'd8,
          BYPASS ? 32'h22222222 : 32'h11111111, 32'h12345678);
    @(posedge Clk);
    @(negedge Clk);
    bus.RegWrite = 1'b0;
    check("hazard_post_edge", 5'd10, 5'd10, 32'h22222222, 32'h22222222);

    // Bypass must never touch index 0 even with a write aimed there
    @(negedge Clk);
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd0; bus.WriteData = 32'h55555555;
    check("r0_no_bypass", 5'd0, 5'd0, 32'h0, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    bus.RegWrite = 1'b0;

    // Reset collides with a write to R4; reset wins and clears prior contents
    write(5'd4, 32'h0000CAFE);
    check("preload_r4", 5'd4, 5'd8, 32'h0000CAFE, 32'h12345678);
    @(negedge Clk);
    Rst = 1'b0;
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd4; bus.WriteData = 32'h0000BEEF;
    check("rst_suppresses_bypass", 5'd4, 5'd31, 32'h0000CAFE, 32'hCAFEF00D);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    bus.RegWrite = 1'b0;
    check("rst_vs_write_r4", 5'd4, 5'd8, 32'h0, 32'h0);
    check("rst_clears_r31_r10", 5'd31, 5'd10, 32'h0, 32'h0);

    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
